// File: rtl/queue_serializer.sv
// Serializes words dequeued from the byte queue onto a valid/ready bit line.
// Latency: 3 edges from an IDLE decision to the first valid bit; bit_ready_in low stalls SHIFT indefinitely.
module queue_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clock_10,
    input  logic                  reset,
    input  logic                  enable_in,
    input  logic [3:0]            q_len_in,
    input  logic [DATA_WIDTH-1:0] q_data_in,
    output logic                  q_deq_out,
    output logic                  serial_out,
    output logic                  bit_valid_out,
    input  logic                  bit_ready_in,
    output logic                  busy_out,
    output logic                  byte_done_out
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                  deq_nxt, serial_nxt, valid_nxt, busy_nxt, done_nxt;
    logic                  xfer, last;

    function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    assign xfer = (state == SHIFT) && bit_valid_out && bit_ready_in;
    assign last = (bit_cnt == LAST_BIT);

    always_ff @(posedge clock_10 or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            q_deq_out     <= 1'b0;
            serial_out    <= 1'b0;
            bit_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            byte_done_out <= 1'b0;
        end else begin
            state         <= state_nxt;
            shreg         <= shreg_nxt;
            bit_cnt       <= bit_cnt_nxt;
            q_deq_out     <= deq_nxt;
            serial_out    <= serial_nxt;
            bit_valid_out <= valid_nxt;
            busy_out      <= busy_nxt;
            byte_done_out <= done_nxt;
        end
    end

    // q_len_in is only tested for non-zero, so occupancies above the queue depth still count as data.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_in && (q_len_in != 4'd0)) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = SHIFT;
            SHIFT:   if (xfer && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port leaves a flop.
    always_comb begin
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        serial_nxt  = serial_out;
        done_nxt    = 1'b0;
        deq_nxt     = (state_nxt == FETCH);
        valid_nxt   = (state_nxt == SHIFT);
        busy_nxt    = (state_nxt != IDLE);
        if (state == WAIT) begin
            shreg_nxt   = q_data_in;
            bit_cnt_nxt = '0;
            serial_nxt  = lead_bit(q_data_in);
        end else if (xfer) begin
            shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            if (last) begin
                done_nxt = 1'b1;
            end else begin
                bit_cnt_nxt = bit_cnt + 1'b1;
                serial_nxt  = lead_bit(shreg_nxt);
            end
        end
    end

endmodule
